// File: rtl/indicador_ocupacion.sv
// LED/flag output stage for the parking-lot counter: shows the count, flashes a
// direction pattern on each car event and blinks all LEDs while the lot is full.
module indicador_ocupacion #(
  parameter int CAPACIDAD = 9,
  parameter int BLINK_DIV = 6000000,
  parameter int EVENT_LEN = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] espacio,
  input  logic       entrada,
  input  logic       salida,
  output logic [3:0] led,
  output logic       lleno,
  output logic       vacio
);
  localparam int TW = (EVENT_LEN > 1) ? $clog2(EVENT_LEN) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(EVENT_LEN - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]    CAP    = 4'(CAPACIDAD);

  typedef enum logic [1:0] {NORMAL, EVENTO, LLENO} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          dir_q, dir_d;      // 1 = salida pattern, 0 = entrada pattern
  logic [3:0]    led_q, led_d;
  logic          lleno_q, lleno_d;
  logic          vacio_q, vacio_d;

  logic evt_in, evt_out, evt, full;
  assign evt_in  = entrada & ~salida;
  assign evt_out = salida & ~entrada;
  assign evt     = evt_in | evt_out;
  assign full    = espacio >= CAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      timer_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      dir_q   <= 1'b0;
      led_q   <= 4'b0000;
      lleno_q <= 1'b0;
      vacio_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      lleno_q <= lleno_d;
      vacio_q <= vacio_d;
    end
  end

  // Blink counter/phase sit at 0/1 outside LLENO, so every entry starts ON.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    cnt_d   = '0;
    phase_d = 1'b1;
    case (state_q)
      NORMAL: begin
        if (evt) begin
          state_d = EVENTO;
          timer_d = T_LOAD;
          dir_d   = evt_out;
        end else if (full) begin
          state_d = LLENO;
        end
      end
      EVENTO: begin
        if (evt) begin
          timer_d = T_LOAD;
          dir_d   = evt_out;
        end else if (timer_q == '0) begin
          state_d = full ? LLENO : NORMAL;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LLENO: begin
        if (evt) begin
          state_d = EVENTO;
          timer_d = T_LOAD;
          dir_d   = evt_out;
        end else if (!full) begin
          state_d = NORMAL;
        end else if (cnt_q == B_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          phase_d = phase_q;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    led_d   = espacio;
    lleno_d = full;
    vacio_d = (espacio == 4'd0);
    case (state_d)
      EVENTO:  led_d = dir_d ? 4'b0011 : 4'b1100;
      LLENO:   led_d = phase_d ? 4'b1111 : 4'b0000;
      default: led_d = espacio;
    endcase
  end

  assign led   = led_q;
  assign lleno = lleno_q;
  assign vacio = vacio_q;
endmodule

// File: tb/tb_indicador_ocupacion.sv
// Bench for indicador_ocupacion: each step pushes hand-derived expected outputs
// to a scoreboard queue, which is popped and checked just after the clock edge.
module tb_indicador_ocupacion;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] espacio = 4'd0;
  logic       entrada = 1'b0;
  logic       salida = 1'b0;
  logic [3:0] led;
  logic       lleno, vacio;

  indicador_ocupacion #(.CAPACIDAD(9), .BLINK_DIV(4), .EVENT_LEN(3)) dut (
    .clk(clk), .rst(rst), .espacio(espacio), .entrada(entrada), .salida(salida),
    .led(led), .lleno(lleno), .vacio(vacio)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic       lleno;
    logic       vacio;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] e,
                      input logic en, input logic sa,
                      input logic [3:0] x_led, input logic x_ll, input logic x_va);
    exp_t x;
    rst = r; espacio = e; entrada = en; salida = sa;
    sb_q.push_back('{tag, x_led, x_ll, x_va});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 4'd0, 4'd1);
    end else begin
      x = sb_q.pop_front();
      chk({x.tag, "_led"},   led,          x.led);
      chk({x.tag, "_lleno"}, {3'b0, lleno}, {3'b0, x.lleno});
      chk({x.tag, "_vacio"}, {3'b0, vacio}, {3'b0, x.vacio});
    end
  endtask

  initial begin
    @(posedge clk); #1;
    // reset and release
    step("rst0", 1, 5, 0, 0, 4'b0000, 0, 0);
    step("rst1", 1, 5, 0, 0, 4'b0000, 0, 0);
    step("rel",  0, 5, 0, 0, 4'b0101, 0, 0);
    // entry flash
    step("in0", 0, 3, 1, 0, 4'b1100, 0, 0);
    step("in1", 0, 3, 0, 0, 4'b1100, 0, 0);
    step("in2", 0, 3, 0, 0, 4'b1100, 0, 0);
    step("in3", 0, 3, 0, 0, 4'b0011, 0, 0);
    // simultaneous pulses ignored
    step("both0", 0, 3, 1, 1, 4'b0011, 0, 0);
    step("both1", 0, 3, 0, 0, 4'b0011, 0, 0);
    // override: salida right after entrada
    step("ov0", 0, 6, 1, 0, 4'b1100, 0, 0);
    step("ov1", 0, 6, 0, 1, 4'b0011, 0, 0);
    step("ov2", 0, 6, 0, 0, 4'b0011, 0, 0);
    step("ov3", 0, 6, 0, 0, 4'b0011, 0, 0);
    step("ov4", 0, 6, 0, 0, 4'b0110, 0, 0);
    // full blink
    step("f8", 0, 8, 0, 0, 4'b1000, 0, 0);
    for (int i = 0; i < 12; i++)
      step($sformatf("blink%0d", i), 0, 9, 0, 0, ((i / 4) == 1) ? 4'b0000 : 4'b1111, 1, 0);
    step("unfull", 0, 8, 0, 0, 4'b1000, 0, 0);
    // event while full
    step("ef0", 0, 9, 0, 0, 4'b1111, 1, 0);
    step("ef1", 0, 9, 0, 0, 4'b1111, 1, 0);
    step("ef2", 0, 9, 0, 1, 4'b0011, 1, 0);
    step("ef3", 0, 9, 0, 0, 4'b0011, 1, 0);
    step("ef4", 0, 9, 0, 0, 4'b0011, 1, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("resume%0d", i), 0, 9, 0, 0, (i < 4) ? 4'b1111 : 4'b0000, 1, 0);
    // reset during EVENTO at timer==1
    step("rm0", 0, 4, 1, 0, 4'b1100, 0, 0);
    step("rm1", 0, 4, 0, 0, 4'b1100, 0, 0);
    step("rm2", 1, 4, 0, 0, 4'b0000, 0, 0);
    step("rm3", 0, 4, 0, 0, 4'b0100, 0, 0);
    step("rm4", 0, 4, 0, 0, 4'b0100, 0, 0);
    step("empty", 0, 0, 0, 0, 4'b0000, 0, 1);
    // above capacity counts as full
    step("over0", 0, 15, 0, 0, 4'b1111, 1, 0);
    step("over1", 0, 2, 0, 0, 4'b0010, 0, 0);
    chk("sb_drained", 4'(sb_q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/indicador_ocupacion.md
Name: indicador_ocupacion

Overview:
- Output stage downstream of the car counter in the parking-lot design.
- Consumes the 4-bit occupancy count `espacio` and the single-cycle `entrada`/`salida` pulses from the direction detector.
- Drives the 4 board LEDs and two status flags.
- Shows the count normally, flashes a direction pattern briefly on each detected car, and blinks all LEDs while the lot is full.

Parameters:
- CAPACIDAD, 9: occupancy at or above which the lot is full (range 1..15).
- BLINK_DIV, 6000000: clk cycles per blink half-period in full mode (0.5 s at 12 MHz).
- EVENT_LEN, 3000000: clk cycles the direction pattern is held after an event (0.25 s at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- espacio  in  4  current occupancy count, unsigned.
- entrada  in  1  one-cycle pulse: car entered.
- salida  in  1  one-cycle pulse: car left.
- led  out  4  LED drive, bit 3 = LED3.
- lleno  out  1  registered: espacio >= CAPACIDAD.
- vacio  out  1  registered: espacio == 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: led=4'b0000, lleno=0, vacio=0, state=NORMAL, event timer=0, blink counter=0, blink phase=1.
- Latency: every output reflects the inputs sampled on the previous rising edge (1 cycle).
- Event qualification:
  - evt_in = entrada & ~salida
  - evt_out = salida & ~entrada
  - both high together is ignored: no state change, no pattern.
- State NORMAL:
  - led = espacio.
  - On evt_in or evt_out -> EVENTO.
  - Else if espacio >= CAPACIDAD -> LLENO.
- State EVENTO:
  - led = 4'b1100 for entrada, 4'b0011 for salida; the latched direction is held for EVENT_LEN cycles.
  - Timer loads EVENT_LEN-1 on entry and decrements each cycle.
  - At timer==0: go to LLENO if espacio >= CAPACIDAD, else NORMAL.
  - A new qualified event during EVENTO reloads the timer and relatches direction; a later event overrides an earlier one.
- State LLENO:
  - led = 4'b1111 when blink phase=1, 4'b0000 when phase=0.
  - Blink counter counts 0..BLINK_DIV-1; on wrap, phase toggles.
  - Counter and phase reset to 0/1 on every entry to LLENO, so the first half-period is always ON.
  - A qualified event -> EVENTO, and events take priority over full.
  - If espacio < CAPACIDAD -> NORMAL with led = espacio next cycle.
- Flags:
  - lleno and vacio update every cycle, independent of state.
  - espacio values above CAPACIDAD count as full; no saturation is applied to the displayed value.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit; no overflow is possible by construction.
- Reset asserted mid-EVENTO or mid-LLENO: next cycle is exactly the reset state, with any pending event discarded.

Test Plan:
- Params CAPACIDAD=9, BLINK_DIV=4, EVENT_LEN=3 for all scenarios.
- Reset test: rst=1 for 2 cycles with espacio=5 -> led=0000, lleno=0, vacio=0; after release, led=0101 one cycle later and vacio=0.
- Entry flash: espacio=3, entrada pulse 1 cycle -> led=1100 for exactly 3 cycles starting one cycle after the pulse, then led=0011 (count 3).
- Simultaneous pulses and override:
  - entrada=salida=1 in the same cycle -> led stays equal to espacio, state NORMAL.
  - salida pulse 1 cycle after an entrada pulse -> led=0011 for 3 cycles after the second pulse.
- Full blink:
  - espacio steps 8->9 -> lleno=1 next cycle.
  - led sequence 1111 x4, 0000 x4, 1111 x4.
  - espacio back to 8 -> led=1000 next cycle, lleno=0.
- Event while full: espacio=9 in LLENO, salida pulse -> led=0011 for 3 cycles, then LLENO resumes starting with 1111 x4.
- Reset mid-operation: rst during EVENTO at timer=1 -> led=0000 next cycle; no pattern after rst drops; espacio=0 gives vacio=1.
